constraint_2_gen: RTL



---
 rtl/constraint_2_pkg.sv | 32 +++
 rtl/constraint_2_chk.sv | 12 +
 rtl/constraint_2_gen.sv | 135 +++++++++++++
 3 files changed

// File: rtl/constraint_2_pkg.sv
// Shared widths, LFSR polynomial, FSM state type and output payload for the
// constraint-2 stimulus generator.
package constraint_2_pkg;

  localparam int unsigned W_VAR20 = 18;
  localparam int unsigned W_VAR2  = 15;
  localparam int unsigned W_LFSR  = 32;
  localparam int unsigned W_TRIES = 4;

  // x^32 + x^22 + x^2 + x + 1, Galois form, right-shifting
  localparam logic [W_LFSR-1:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_HOLD = 2'd2
  } c2_state_t;

  // One emitted vector plus its side-band information
  typedef struct packed {
    logic [W_VAR20-1:0] var_20;
    logic [W_VAR2-1:0]  var_2;
    logic [W_TRIES-1:0] tries;
    logic               forced;
  } c2_vec_t;

  // Single Galois step: shift right, fold the dropped bit back through the taps
  function automatic logic [W_LFSR-1:0] lfsr_next(input logic [W_LFSR-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/constraint_2_chk.sv
// Constraint-2 predicate: (var_20 != 0) -> (var_2 != 0).
module constraint_2_chk
  import constraint_2_pkg::*;
(
  input  logic [W_VAR20-1:0] var_20,
  input  logic [W_VAR2-1:0]  var_2,
  output logic               ok
);

  assign ok = (var_20 == '0) || (var_2 != '0);

endmodule

// File: rtl/constraint_2_gen.sv
// Constrained-random var_20/var_2 generator for constraint 2: LFSR candidates,
// rejection sampling, valid/ready delivery.
// Build option: define CONSTRAINT_2_REPAIR_EN to force var_2 = 1 after
// MAX_TRIES rejections; otherwise retries are unbounded and forced stays 0.
module constraint_2_gen
  import constraint_2_pkg::*;
#(
  parameter logic [W_LFSR-1:0] SEED      = 32'hACE1_2024,
  parameter int unsigned       MAX_TRIES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               seed_load,
  input  logic [W_LFSR-1:0]  seed_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W_VAR20-1:0] var_20,
  output logic [W_VAR2-1:0]  var_2,
  output logic [W_TRIES-1:0] tries,
  output logic               forced
);

`ifdef CONSTRAINT_2_REPAIR_EN
  localparam bit REPAIR_EN = 1'b1;
`else
  localparam bit REPAIR_EN = 1'b0;
`endif

  localparam logic [W_TRIES-1:0] TRY_LIMIT = W_TRIES'(MAX_TRIES);
  localparam logic [W_TRIES-1:0] TRY_SAT   = '1;
  // A zero LFSR would lock up, so a zero seed falls back to SEED
  localparam logic [W_LFSR-1:0]  SEED_SAFE = (SEED == '0) ? W_LFSR'(1) : SEED;

  c2_state_t          state_q, state_d;
  logic [W_LFSR-1:0]  lfsr_q, lfsr_d;
  logic [W_TRIES-1:0] cnt_q, cnt_d;
  c2_vec_t            vec_q, vec_d;
  logic               valid_q, valid_d;

  logic [W_VAR20-1:0] cand_20;
  logic [W_VAR2-1:0]  cand_2;
  logic               cand_ok;
  logic [W_LFSR-1:0]  seed_val;

  // Candidate fields overlap on LFSR bit 17
  assign cand_20  = lfsr_q[W_VAR20-1:0];
  assign cand_2   = lfsr_q[W_LFSR-1:W_LFSR-W_VAR2];
  assign seed_val = (seed_in == '0) ? SEED_SAFE : seed_in;

  constraint_2_chk u_chk (
    .var_20 (cand_20),
    .var_2  (cand_2),
    .ok     (cand_ok)
  );

  // State, LFSR, try counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lfsr_q  <= SEED_SAFE;
      cnt_q   <= '0;
      vec_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      valid_q <= valid_d;
    end
  end

  // Next-state and next-output logic; seed_load flushes from any state
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    valid_d = valid_q;

    if (seed_load) begin
      lfsr_d  = seed_val;
      state_d = ST_IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          valid_d = 1'b0;
          if (en) state_d = ST_GEN;
        end
        ST_GEN: begin
          lfsr_d = lfsr_next(lfsr_q);
          if (cand_ok) begin
            vec_d.var_20 = cand_20;
            vec_d.var_2  = cand_2;
            vec_d.tries  = cnt_q;
            vec_d.forced = 1'b0;
            valid_d      = 1'b1;
            state_d      = ST_HOLD;
          end else if (REPAIR_EN && (cnt_q == TRY_LIMIT)) begin
            vec_d.var_20 = cand_20;
            vec_d.var_2  = W_VAR2'(1);
            vec_d.tries  = cnt_q;
            vec_d.forced = 1'b1;
            valid_d      = 1'b1;
            state_d      = ST_HOLD;
          end else if (cnt_q != TRY_SAT) begin
            cnt_d = cnt_q + W_TRIES'(1);
          end
        end
        ST_HOLD: begin
          valid_d = 1'b1;
          if (out_ready) begin
            valid_d = 1'b0;
            cnt_d   = '0;
            state_d = en ? ST_GEN : ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  assign out_valid = valid_q;
  assign var_20    = vec_q.var_20;
  assign var_2     = vec_q.var_2;
  assign tries     = vec_q.tries;
  assign forced    = vec_q.forced;

endmodule
